// File: rtl/afifo_pkg.sv
// Shared types and constants for the async FIFO and its read-side stages.
package afifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } rd_stage_state_e;

    localparam int AFIFO_DSIZE = 32;

endpackage

// File: rtl/afifo_rd_stage.sv
// Read-side output stage for afifo: pops the FIFO into a 2-entry buffer and presents
// the head word as a registered valid/ready stream.
module afifo_rd_stage
    import afifo_pkg::*;
#(
    parameter int DSIZE = AFIFO_DSIZE,
    parameter int CNTW  = 32
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNTW-1:0]  beat_cnt
);

    rd_stage_state_e  state_q, state_d;
    logic [DSIZE-1:0] mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]  beat_cnt_q;
    logic             push, pop;

    // rinc depends only on the afifo flag and registered state, never on out_ready.
    assign rinc      = !rempty && (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = rinc;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rd_ptr_q];
    assign occupancy = state_q;
    assign beat_cnt  = beat_cnt_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (!push && pop) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q    <= EMPTY;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                mem_q[wr_ptr_q] <= rdata;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q   <= !rd_ptr_q;
                beat_cnt_q <= beat_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end
    end

    a_no_rinc_when_empty: assert property (
        @(posedge rclk) disable iff (!rrst_n) !(rinc && rempty));

    a_state_legal: assert property (
        @(posedge rclk) disable iff (!rrst_n) state_q inside {EMPTY, ONE, FULL});

    a_data_stable: assert property (
        @(posedge rclk) disable iff (!rrst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_afifo_rd_stage.sv
// Directed and randomised bench for afifo_rd_stage against a queue-based FIFO model.
module tb_afifo_rd_stage;

    localparam int DSIZE = 32;
    localparam int CNTW  = 32;

    logic             rclk = 1'b0;
    logic             rrst_n;
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic             out_valid;
    logic             out_ready;
    logic [DSIZE-1:0] out_data;
    logic [1:0]       occupancy;
    logic [CNTW-1:0]  beat_cnt;

    afifo_rd_stage #(.DSIZE(DSIZE), .CNTW(CNTW)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .beat_cnt  (beat_cnt)
    );

    always #5 rclk = !rclk;

    logic [DSIZE-1:0] fifo_q [$];     // words still inside the afifo
    logic [DSIZE-1:0] exp_q [$];      // words the stage should be holding, head first
    logic [DSIZE-1:0] delivered [$];  // words accepted by the consumer
    logic             empty_force;
    int               beats;
    int               n_checks;
    int               n_pass;
    logic             last_rinc;
    logic             last_valid;
    logic [9:0]       rinc_hist;
    logic [9:0]       valid_hist;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive();
        rempty = (fifo_q.size() == 0) || empty_force;
        rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    // Observe at the falling edge, then commit the model after the rising edge.
    task automatic tick();
        logic             do_push, do_pop;
        logic [DSIZE-1:0] head;
        @(negedge rclk);
        check("occupancy", 64'(occupancy), 64'(exp_q.size()));
        check("rinc", 64'(rinc), 64'(!rempty && exp_q.size() < 2));
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        do_push = rinc;
        do_pop  = out_valid && out_ready;
        head    = out_data;
        last_rinc  = rinc;
        last_valid = out_valid;
        if (do_pop && exp_q.size() != 0) check("out_data", 64'(out_data), 64'(exp_q[0]));
        if (do_push && fifo_q.size() == 0) check("pop_of_empty_fifo", 64'(1), 64'(0));
        @(posedge rclk);
        #1;
        if (do_pop && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            delivered.push_back(head);
            beats++;
        end
        if (do_push && fifo_q.size() != 0) exp_q.push_back(fifo_q.pop_front());
        drive();
    endtask

    initial begin
        n_checks = 0; n_pass = 0; beats = 0;
        empty_force = 1'b0;
        rrst_n = 1'b0; rempty = 1'b1; rdata = '0; out_ready = 1'b0;

        // 1. Reset
        repeat (3) @(posedge rclk);
        #2;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_rinc", 64'(rinc), 64'(0));
        check("rst_occupancy", 64'(occupancy), 64'(0));
        check("rst_beat_cnt", 64'(beat_cnt), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        rrst_n = 1'b1;
        @(posedge rclk);
        #1;

        // 2. Streaming 0x11..0x18
        for (int i = 0; i < 8; i++) fifo_q.push_back(DSIZE'(32'h11 + i));
        out_ready = 1'b1;
        drive();
        for (int i = 0; i < 10; i++) begin
            tick();
            rinc_hist[i]  = last_rinc;
            valid_hist[i] = last_valid;
        end
        check("stream_rinc_hist", 64'(rinc_hist), 64'(10'h0FF));
        check("stream_valid_hist", 64'(valid_hist), 64'(10'h1FE));
        check("stream_beat_cnt", 64'(beat_cnt), 64'(8));
        check("stream_first", 64'(delivered[0]), 64'(32'h11));
        check("stream_last", 64'(delivered[7]), 64'(32'h18));

        // 3. Back-pressure
        out_ready = 1'b0;
        fifo_q.push_back(32'hA0); fifo_q.push_back(32'hA1); fifo_q.push_back(32'hA2);
        drive();
        repeat (4) tick();
        check("bp_occupancy", 64'(occupancy), 64'(2));
        check("bp_rinc", 64'(rinc), 64'(0));
        check("bp_out_data", 64'(out_data), 64'(32'hA0));
        out_ready = 1'b1;
        repeat (4) tick();
        check("bp_count", 64'(delivered.size()), 64'(11));
        check("bp_word0", 64'(delivered[8]), 64'(32'hA0));
        check("bp_word1", 64'(delivered[9]), 64'(32'hA1));
        check("bp_word2", 64'(delivered[10]), 64'(32'hA2));
        check("bp_beat_cnt", 64'(beat_cnt), 64'(11));

        // 4. Simultaneous push/pop in ONE
        for (int i = 0; i < 6; i++) fifo_q.push_back(DSIZE'(32'h30 + i));
        drive();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("pp_occupancy", 64'(occupancy), 64'(1));
        end
        repeat (2) tick();
        for (int i = 0; i < 6; i++) check("pp_order", 64'(delivered[11+i]), 64'(32'h30 + i));

        // 5. Random rempty/out_ready
        for (int c = 0; c < 10000; c++) begin
            if (fifo_q.size() < 3)
                for (int k = 0; k < 3; k++) fifo_q.push_back(DSIZE'($urandom));
            empty_force = ($urandom_range(0, 3) == 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            drive();
            tick();
        end
        empty_force = 1'b0;
        check("rand_beat_cnt", 64'(beat_cnt), 64'(beats));

        // 6. Reset while FULL
        fifo_q.delete();
        fifo_q.push_back(32'hB0); fifo_q.push_back(32'hB1); fifo_q.push_back(32'hB2);
        out_ready = 1'b0;
        drive();
        repeat (3) tick();
        check("rf_full", 64'(occupancy), 64'(2));
        #2;
        rrst_n = 1'b0;
        rempty = 1'b1;
        #1;
        check("rf_out_valid", 64'(out_valid), 64'(0));
        check("rf_occupancy", 64'(occupancy), 64'(0));
        check("rf_out_data", 64'(out_data), 64'(0));
        check("rf_beat_cnt", 64'(beat_cnt), 64'(0));
        check("rf_rinc", 64'(rinc), 64'(0));
        repeat (2) @(posedge rclk);
        #3;
        rrst_n = 1'b1;
        fifo_q.delete(); exp_q.delete(); delivered.delete();
        beats = 0;
        fifo_q.push_back(32'hC0);
        out_ready = 1'b1;
        drive();
        repeat (3) tick();
        check("rf_fresh_count", 64'(delivered.size()), 64'(1));
        if (delivered.size() != 0) check("rf_fresh_word", 64'(delivered[0]), 64'(32'hC0));
        check("rf_fresh_beat", 64'(beat_cnt), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
